// File: rtl/aes_pkg.sv
// Shared AES types and the forward S-box constant table used by the
// round datapath and the key scheduler.
package aes_pkg;

  typedef logic [15:0][7:0] aes_128;
  typedef logic [3:0][7:0]  aes_32;
  typedef logic [7:0]       aes_byte;

  // Forward S-box: GF(2^8) inverse (0 maps to 0) followed by the affine
  // transform with constant 0x63. Indexed directly by the input byte.
  localparam aes_byte SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sbox_byte.sv
// Single-byte forward S-box lookup; purely combinational, defined for
// all 256 inputs.
module aes_sbox_byte
  import aes_pkg::*;
(
  input  aes_byte byte_i,
  output aes_byte byte_o
);

  assign byte_o = SBOX[byte_i];

endmodule

// File: rtl/aes_sbox.sv
// Registered S-box bank shared by the round datapath (16 state bytes)
// and the key scheduler (4 key-word bytes). key_gen picks which output
// register loads on a given cycle; the other one holds.
module aes_sbox
  import aes_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  aes_128 in,
  input  aes_32  key_in,
  input  logic   key_gen,
  output aes_128 out,
  output aes_32  key_out
);

  aes_128 out_d, out_q;
  aes_32  key_d, key_q;

  // Positional byte mapping: byte k in feeds byte k out, no reordering.
  for (genvar k = 0; k < 16; k++) begin : g_state
    aes_sbox_byte u_state_byte (
      .byte_i (in[k]),
      .byte_o (out_d[k])
    );
  end

  for (genvar k = 0; k < 4; k++) begin : g_key
    aes_sbox_byte u_key_byte (
      .byte_i (key_in[k]),
      .byte_o (key_d[k])
    );
  end

  // Output registers: reset wins, then key_gen selects the path that loads.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      out_q <= '0;
      key_q <= '0;
    end else if (key_gen) begin
      key_q <= key_d;
    end else begin
      out_q <= out_d;
    end
  end

  assign out     = out_q;
  assign key_out = key_q;

endmodule

// File: tb/tb_aes_sbox.sv
// Scoreboard bench for aes_sbox: the driver pushes the expected register
// contents for every edge, and a negedge monitor pops and compares them.
// Expected S-box values come from hand constants or from an independent
// GF(2^8) inverse + affine model built at time zero.
module tb_aes_sbox;
  import aes_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  aes_128 in_s;
  aes_32  key_in_s;
  logic   key_gen;
  aes_128 out_s;
  aes_32  key_out_s;

  always #5 clk = ~clk;

  aes_sbox dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in_s),
    .key_in  (key_in_s),
    .key_gen (key_gen),
    .out     (out_s),
    .key_out (key_out_s)
  );

  typedef struct {
    aes_128 exp_out;
    aes_32  exp_key;
    int     id;
  } exp_t;

  exp_t    sb[$];
  int      n_cmp = 0;
  int      n_bad = 0;
  int      vec_id = 0;
  aes_byte model [256];
  aes_128  m_out;
  aes_32   m_key;

  function automatic aes_byte gf_mul(aes_byte a, aes_byte b);
    aes_byte p = 8'h00;
    aes_byte x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic aes_byte affine(aes_byte v);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
             ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  task automatic check(input string name, input int id,
                       input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h expected %h", name, id, act, req);
    end
  endtask

  // Monitor: one registered result is visible per cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("out", e.id, out_s, e.exp_out);
      check("key_out", e.id, {96'h0, key_out_s}, {96'h0, e.exp_key});
    end
  end

  // Drive one cycle; the expected registers follow the reference model.
  task automatic drive(input logic r, input logic kg, input aes_128 i, input aes_32 k);
    @(negedge clk);
    rst = r; key_gen = kg; in_s = i; key_in_s = k;
    if (r) begin
      m_out = '0;
      m_key = '0;
    end else if (kg) begin
      for (int b = 0; b < 4; b++) m_key[b] = model[k[b]];
    end else begin
      for (int b = 0; b < 16; b++) m_out[b] = model[i[b]];
    end
    @(posedge clk);
    sb.push_back('{m_out, m_key, vec_id});
    vec_id++;
  endtask

  // Drive one cycle with hand-computed expected register contents.
  task automatic drive_hand(input logic r, input logic kg, input aes_128 i, input aes_32 k,
                            input aes_128 h_out, input aes_32 h_key);
    @(negedge clk);
    rst = r; key_gen = kg; in_s = i; key_in_s = k;
    m_out = h_out;
    m_key = h_key;
    @(posedge clk);
    sb.push_back('{m_out, m_key, vec_id});
    vec_id++;
  endtask

  initial begin
    aes_128 iv;
    aes_32  kv;
    aes_128 held;
    aes_byte inv;

    rst = 1'b1; key_gen = 1'b0; in_s = '1; key_in_s = '1;
    m_out = '0; m_key = '0;

    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gf_mul(aes_byte'(a), aes_byte'(b)) == 8'h01) inv = aes_byte'(b);
      model[a] = affine(inv);
    end

    // Reset with all-ones inputs, then release with key_gen=0.
    drive_hand(1'b1, 1'b0, '1, '1, '0, '0);
    drive_hand(1'b1, 1'b0, '1, '1, '0, '0);
    drive_hand(1'b0, 1'b0, '1, '1, {16{8'h16}}, '0);

    // Directed state bytes: 00->63, 53->ED, FF->16.
    iv = '0; iv[1] = 8'h53; iv[2] = 8'hff;
    drive_hand(1'b0, 1'b0, iv, '0, {{13{8'h63}}, 8'h16, 8'hed, 8'h63}, '0);

    // Exhaustive sweep of each state byte position.
    for (int k = 0; k < 16; k++) begin
      for (int v = 0; v < 256; v++) begin
        iv = '0;
        iv[k] = aes_byte'(v);
        drive(1'b0, 1'b0, iv, '0);
      end
    end

    // Key path {CF,4F,3C,09} -> {8A,84,EB,01}; state register holds.
    held = {8'h16, {15{8'h63}}};
    kv = {8'h09, 8'h3c, 8'h4f, 8'hcf};
    drive_hand(1'b0, 1'b1, '1, kv, held, {8'h01, 8'heb, 8'h84, 8'h8a});
    kv = {8'hff, 8'h00, 8'hc9, 8'h01};
    drive_hand(1'b0, 1'b1, '0, kv, held, {8'h16, 8'h63, 8'hdd, 8'h7c});

    // Exhaustive sweep of each key byte position.
    for (int k = 0; k < 4; k++) begin
      for (int v = 0; v < 256; v++) begin
        kv = '0;
        kv[k] = aes_byte'(v);
        drive(1'b0, 1'b1, '1, kv);
      end
    end

    // Alternate key_gen with changing inputs: only the selected register loads.
    for (int n = 0; n < 40; n++) begin
      for (int b = 0; b < 16; b++) iv[b] = aes_byte'($urandom_range(0, 255));
      for (int b = 0; b < 4; b++)  kv[b] = aes_byte'($urandom_range(0, 255));
      drive(1'b0, n[0], iv, kv);
    end

    // Reset mid-stream with in = {00..0F}, then resume.
    for (int b = 0; b < 16; b++) iv[b] = aes_byte'(b);
    drive(1'b0, 1'b0, iv, '0);
    drive_hand(1'b1, 1'b0, iv, '1, '0, '0);
    drive_hand(1'b0, 1'b0, iv, '1, 128'h76abd7fe2b670130c56f6bf27b777c63, '0);
    drive_hand(1'b0, 1'b1, '0, {8'h09, 8'h3c, 8'h4f, 8'hcf},
               128'h76abd7fe2b670130c56f6bf27b777c63, {8'h01, 8'heb, 8'h84, 8'h8a});

    // Let the monitor drain the scoreboard, bounded.
    for (int t = 0; t < 10 && sb.size() != 0; t++) @(negedge clk);
    @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_sbox.md
Name: aes_sbox

Overview:
- Registered AES S-box bank (FIPS-197 SubBytes forward S-box).
- Substitutes all 16 bytes of a 128-bit state for the round datapath.
- Also substitutes a 32-bit word (SubWord) for the key-expansion path.
- `key_gen` selects which path updates on a given cycle. The block sits between AddRoundKey and ShiftRows in the cipher core and is shared with the key scheduler.

Parameters:
- None. All widths are fixed by aes_pkg types.

Ports:
- `clk`      input   1    rising-edge clock
- `rst`      input   1    synchronous, active-high reset
- `in`       input   aes_128 (16x8)   state bytes; `in[k]` is byte k
- `key_in`   input   aes_32 (4x8)     key word bytes; `key_in[k]` is byte k
- `key_gen`  input   1    0 = state substitution cycle, 1 = key-word substitution cycle
- `out`      output  aes_128 (16x8)   registered SubBytes(in)
- `key_out`  output  aes_32 (4x8)     registered SubWord(key_in)

Behaviour:
- Reset is synchronous, active-high. On any rising `clk` with `rst`=1:
  - `out` becomes 0.
  - `key_out` becomes 0.
  - `rst` has priority over `key_gen`.
- With `rst`=0 and `key_gen`=0 on a rising `clk`:
  - `out[k]` <= S(`in[k]`) for k = 0..15.
  - `key_out` holds its value.
- With `rst`=0 and `key_gen`=1 on a rising `clk`:
  - `key_out[k]` <= S(`key_in[k]`) for k = 0..3.
  - `out` holds its value.
- Latency is 1 cycle from input sample to output. Throughput is one substitution per cycle per path.
- Byte mapping is positional:
  - Byte k in maps to byte k out.
  - No rotation, shifting or reordering. RotWord belongs to the key scheduler, not here.
- S is the standard AES forward S-box:
  - Multiplicative inverse in GF(2^8), modulus x^8+x^4+x^3+x+1, with 0 mapped to 0.
  - Followed by the affine transform with constant 0x63.
  - Required values: S(00)=63, S(01)=7C, S(53)=ED, S(C9)=DD, S(FF)=16.
- Each byte lookup is independent and purely combinational before the output register. There are no X-propagating branches: all 256 inputs are defined.
- No handshake: inputs are sampled every enabled cycle.
- Reset asserted mid-operation discards any pending result; the first post-reset result appears one cycle after `rst` deasserts.

Decomposition:
- aes_pkg:
  - `typedef logic [15:0][7:0] aes_128;`
  - `typedef logic [3:0][7:0] aes_32;`
  - `typedef logic [7:0] aes_byte;`
  - 256-entry S-box constant table `SBOX` (`aes_byte [0:255]`).
- One sub-module, aes_sbox_byte:
  - Combinational 8-bit in / 8-bit out lookup of `SBOX`.
  - Instantiated 20 times: 16 for state, 4 for key.
- The top level holds only the generate loops and the two output registers with the `key_gen` enables.

Test Plan:
- Reset: drive `rst`=1 for 2 cycles with `in` = all FF and `key_in` = FFFFFFFF → `out` = 0 and `key_out` = 0; after release with `key_gen`=0, the next edge gives every `out` byte = 16.
- Exhaustive state: `key_gen`=0; for each byte position k = 0..15 sweep `in[k]` over 00..FF (others 00) → one cycle later `out[k]` equals the table value (00→63, 53→ED, FF→16) and all other bytes = 63.
- Key path: `key_gen`=1, `key_in` bytes {CF,4F,3C,09} → `key_out` = {8A,84,EB,01} after 1 cycle; `out` is unchanged from its prior value.
- Hold behaviour: alternate `key_gen` 0/1 each cycle while changing `in`/`key_in` → only the selected register updates; the other retains its last value.
- Reset mid-stream: assert `rst` on the cycle after `in` = {00..0F} is applied → outputs read 0, not S(`in`), then resume correctly after deassertion.
- Exhaustive key bytes: sweep `key_in[k]` over 00..FF for k = 0..3 with `key_gen`=1 → `key_out[k]` matches the S-box; 01→7C, C9→DD.
